// File: rtl/pwm_pkg.sv
// pwm_pkg: constants and types shared by the PWM generator and PWM capture
// blocks. The optional input deglitcher is enabled with PWM_GLITCH_FILT_EN.
package pwm_pkg;

  // Generator counter width; the nominal PWM period is 2**PWM_WIDTH clocks.
  localparam int PWM_WIDTH = 10;

  // The measurement counter is two bits wider than the generator counter, so
  // it can hold up to four nominal periods before saturating.
  function automatic int cw_of(input int width);
    return width + 2;
  endfunction

  localparam int PWM_CW = cw_of(PWM_WIDTH);

  // Capture FSM states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } capture_state_e;

endpackage

// File: rtl/pwm_sync_edge.sv
// pwm_sync_edge: brings an asynchronous level into the clk domain and reports
// single-cycle rise/fall strobes plus the level those strobes refer to.
// If PWM_GLITCH_FILT_EN is defined, a deglitcher follows the synchroniser. The
// filtered level then moves only after the synced input has held a new value
// for 3 consecutive clocks.
module pwm_sync_edge
  import pwm_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_d, sync_q;
  logic                   lvl_d, lvl_q;
  logic                   rise_d, rise_q;
  logic                   fall_d, fall_q;
  logic                   s;

  assign s = sync_q[SYNC_STAGES-1];

  // Shift the asynchronous input through the synchroniser chain.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], async_in};
  end

`ifdef PWM_GLITCH_FILT_EN
  logic [1:0] flt_cnt_d, flt_cnt_q;

  // Deglitcher. lvl_q is the filtered level. It takes the synced value on the
  // third consecutive clock that disagrees with it. Any agreeing clock
  // restarts the count, so pulses of 1-2 clocks never reach lvl_q.
  always_comb begin
    lvl_d     = lvl_q;
    flt_cnt_d = 2'd0;
    if (s != lvl_q) begin
      if (flt_cnt_q == 2'd2) begin
        lvl_d     = s;
        flt_cnt_d = 2'd0;
      end else begin
        flt_cnt_d = flt_cnt_q + 2'd1;
      end
    end
  end

  // Deglitcher counter register.
  always_ff @(posedge clk) begin
    if (rst) flt_cnt_q <= 2'd0;
    else     flt_cnt_q <= flt_cnt_d;
  end
`else
  // No filter: lvl_q is simply the synced level delayed one clock, which
  // provides the edge-detect reference.
  always_comb begin
    lvl_d = s;
  end
`endif

  // Edge strobes compare the next level with the current one. They are
  // registered, so each strobe lines up with lvl_q already at the new level.
  always_comb begin
    rise_d = lvl_d & ~lvl_q;
    fall_d = ~lvl_d & lvl_q;
  end

  // Synchroniser, level and edge registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      lvl_q  <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      lvl_q  <= lvl_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign level = lvl_q;
  assign rise  = rise_q;
  assign fall  = fall_q;

endmodule

// File: rtl/pwm_capture.sv
// pwm_capture: measures an incoming asynchronous PWM waveform and reports the
// high time and period of each complete cycle. It flags a stuck line when no
// edge arrives for TIMEOUT clocks.
// Build option PWM_GLITCH_FILT_EN enables the input deglitcher in pwm_sync_edge.
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int WIDTH       = PWM_WIDTH,
  parameter int CW          = cw_of(WIDTH),
  parameter int TIMEOUT     = 2 * (2 ** WIDTH),
  parameter int SYNC_STAGES = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          PWM_in,
  output logic [CW-1:0] high_time,
  output logic [CW-1:0] period,
  output logic          meas_vld,
  output logic          stuck_hi,
  output logic          stuck_lo
);

  localparam int            IW      = $clog2(TIMEOUT + 1);
  localparam logic [IW-1:0] TO_LAST = IW'(TIMEOUT - 1);
  localparam logic [IW-1:0] TO_MAX  = IW'(TIMEOUT);

  logic           lvl, rise, fall;
  capture_state_e state_d, state_q;
  logic [CW-1:0]  hcnt_d, hcnt_q;
  logic [CW-1:0]  pcnt_d, pcnt_q;
  logic [IW-1:0]  idle_d, idle_q;
  logic [CW-1:0]  high_time_d, high_time_q;
  logic [CW-1:0]  period_d, period_q;
  logic           meas_vld_d, meas_vld_q;
  logic           stuck_hi_d, stuck_hi_q;
  logic           stuck_lo_d, stuck_lo_q;

  // Measurement counters stick at all-ones instead of wrapping.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  pwm_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_edge (
    .clk     (clk),
    .rst     (rst),
    .async_in(PWM_in),
    .level   (lvl),
    .rise    (rise),
    .fall    (fall)
  );

  // Next-state logic: edge-driven measurement FSM, then the stuck-line
  // timeout, which takes priority over the FSM.
  always_comb begin
    state_d     = state_q;
    hcnt_d      = hcnt_q;
    pcnt_d      = pcnt_q;
    idle_d      = idle_q;
    high_time_d = high_time_q;
    period_d    = period_q;
    meas_vld_d  = 1'b0;
    stuck_hi_d  = stuck_hi_q;
    stuck_lo_d  = stuck_lo_q;

    case (state_q)
      // The first period after IDLE is partial, so it only arms the counters.
      IDLE: begin
        if (rise) begin
          state_d = HIGH;
          hcnt_d  = CW'(1);
          pcnt_d  = CW'(1);
        end
      end
      HIGH: begin
        pcnt_d = sat_inc(pcnt_q);
        if (fall) state_d = LOW;
        else      hcnt_d  = sat_inc(hcnt_q);
      end
      // A rise closes the period: publish it and start the next one.
      LOW: begin
        if (rise) begin
          high_time_d = hcnt_q;
          period_d    = pcnt_q;
          meas_vld_d  = 1'b1;
          state_d     = HIGH;
          hcnt_d      = CW'(1);
          pcnt_d      = CW'(1);
        end else begin
          pcnt_d = sat_inc(pcnt_q);
        end
      end
      default: state_d = IDLE;
    endcase

    if (rise || fall) begin
      idle_d     = '0;
      stuck_hi_d = 1'b0;
      stuck_lo_d = 1'b0;
    end else if (idle_q != TO_MAX) begin
      idle_d = idle_q + 1'b1;
      if (idle_q == TO_LAST) begin
        stuck_hi_d = lvl;
        stuck_lo_d = ~lvl;
        state_d    = IDLE;
        hcnt_d     = '0;
        pcnt_d     = '0;
      end
    end
  end

  // State, counter and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      hcnt_q      <= '0;
      pcnt_q      <= '0;
      idle_q      <= '0;
      high_time_q <= '0;
      period_q    <= '0;
      meas_vld_q  <= 1'b0;
      stuck_hi_q  <= 1'b0;
      stuck_lo_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      hcnt_q      <= hcnt_d;
      pcnt_q      <= pcnt_d;
      idle_q      <= idle_d;
      high_time_q <= high_time_d;
      period_q    <= period_d;
      meas_vld_q  <= meas_vld_d;
      stuck_hi_q  <= stuck_hi_d;
      stuck_lo_q  <= stuck_lo_d;
    end
  end

  assign high_time = high_time_q;
  assign period    = period_q;
  assign meas_vld  = meas_vld_q;
  assign stuck_hi  = stuck_hi_q;
  assign stuck_lo  = stuck_lo_q;

endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: directed bench for pwm_capture. It drives generator-style
// loopback waveforms, a stuck line, a mid-measurement reset, a short external
// waveform and a glitch, and checks each result against hand-computed values.
module tb_pwm_capture;

  localparam int CW = 12;

  logic          clk;
  logic          rst;
  logic          PWM_in;
  logic [CW-1:0] high_time;
  logic [CW-1:0] period;
  logic          meas_vld;
  logic          stuck_hi;
  logic          stuck_lo;

  int total = 0;
  int bad   = 0;

  // Record of meas_vld pulses, sampled on the falling edge.
  int            vld_cnt = 0;
  logic [CW-1:0] last_ht = '0;
  logic [CW-1:0] last_per = '0;
  int            snap;

  pwm_capture dut (
    .clk      (clk),
    .rst      (rst),
    .PWM_in   (PWM_in),
    .high_time(high_time),
    .period   (period),
    .meas_vld (meas_vld),
    .stuck_hi (stuck_hi),
    .stuck_lo (stuck_lo)
  );

  // Clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Measurement monitor.
  always @(negedge clk) begin
    if (meas_vld === 1'b1) begin
      vld_cnt  = vld_cnt + 1;
      last_ht  = high_time;
      last_per = period;
    end
  end

  // Advance n clocks and settle just after the last rising edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One PWM period: hi clocks high, then per-hi clocks low.
  task automatic gen_period(input int hi, input int per);
    PWM_in = 1'b1;
    tick(hi);
    PWM_in = 1'b0;
    tick(per - hi);
  endtask

  task automatic chk(input string tag, input int got, input int exp);
    total = total + 1;
    assert (got === exp) else begin
      bad = bad + 1;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  initial begin
    // Reset state.
    rst    = 1'b1;
    PWM_in = 1'b0;
    tick(3);
    chk("rst_high_time", int'(high_time), 0);
    chk("rst_period", int'(period), 0);
    chk("rst_meas_vld", int'(meas_vld), 0);
    chk("rst_stuck_hi", int'(stuck_hi), 0);
    chk("rst_stuck_lo", int'(stuck_lo), 0);
    rst = 1'b0;
    tick(5);

    // Loopback, duty 0x100: generator high for d+1 = 257 of 1024 clocks.
    // Four rises give three complete periods.
    snap = vld_cnt;
    for (int i = 0; i < 4; i++) gen_period(257, 1024);
    chk("d100_count", vld_cnt - snap, 3);
    chk("d100_high_time", int'(last_ht), 257);
    chk("d100_period", int'(last_per), 1024);

    // Duty changes to 0x2FF on a period boundary. The first rise closes the
    // last 0x100 period, and the next three report 768.
    snap = vld_cnt;
    for (int i = 0; i < 4; i++) gen_period(768, 1024);
    chk("d2ff_count", vld_cnt - snap, 4);
    chk("d2ff_high_time", int'(last_ht), 768);
    chk("d2ff_period", int'(last_per), 1024);

    // Line held high. The rise closes the last 768 period. After that there
    // are no measurements, and stuck_hi follows about 2048 clocks after sync.
    snap   = vld_cnt;
    PWM_in = 1'b1;
    tick(2040);
    chk("stuck_early_count", vld_cnt - snap, 1);
    chk("stuck_hi_early", int'(stuck_hi), 0);
    tick(20);
    chk("stuck_hi_set", int'(stuck_hi), 1);
    chk("stuck_lo_clear", int'(stuck_lo), 0);
    chk("stuck_hold_high_time", int'(high_time), 768);
    chk("stuck_hold_period", int'(period), 1024);
    chk("stuck_no_vld", vld_cnt - snap, 1);

    // A falling edge releases the flag.
    PWM_in = 1'b0;
    tick(10);
    chk("stuck_hi_released", int'(stuck_hi), 0);

    // Reset for one cycle while the FSM is in LOW.
    PWM_in = 1'b1;
    tick(5);
    PWM_in = 1'b0;
    tick(20);
    rst = 1'b1;
    tick(1);
    chk("midrst_high_time", int'(high_time), 0);
    chk("midrst_period", int'(period), 0);
    chk("midrst_meas_vld", int'(meas_vld), 0);
    chk("midrst_stuck_hi", int'(stuck_hi), 0);
    chk("midrst_stuck_lo", int'(stuck_lo), 0);
    rst = 1'b0;

    // External waveform, 5 high / 95 low, measured fresh from IDLE.
    snap = vld_cnt;
    for (int i = 0; i < 3; i++) gen_period(5, 100);
    chk("ext_count", vld_cnt - snap, 2);
    chk("ext_high_time", int'(last_ht), 5);
    chk("ext_period", int'(last_per), 100);

    // A 2-clock spike 40 clocks into LOW, followed by one clean period.
    snap   = vld_cnt;
    PWM_in = 1'b1;
    tick(5);
    PWM_in = 1'b0;
    tick(40);
    PWM_in = 1'b1;
    tick(2);
    PWM_in = 1'b0;
    tick(53);
    gen_period(5, 100);
`ifdef PWM_GLITCH_FILT_EN
    // The spike is filtered out, so only real periods are reported.
    chk("spike_count", vld_cnt - snap, 2);
    chk("spike_high_time", int'(last_ht), 5);
    chk("spike_period", int'(last_per), 100);
`else
    // The spike counts as a pulse. It splits the period into 45 (5 high) and
    // 55 (2 high).
    chk("spike_count", vld_cnt - snap, 3);
    chk("spike_high_time", int'(last_ht), 2);
    chk("spike_period", int'(last_per), 55);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
